inst_fetch_ctrl: RTL and testbench

- Fetch-stage controller: generates the fetch PC and drives the SRAM-like instruction bus (req/addr_ok/data_ok).
- Captures returned instructions and hands them to the decode stage over a valid/allowin handshake.
- Sits between the PC-redirect sources (branch from EX, flush from WB/CSR) and the decode stage.
- Keeps at most one outstanding bus transaction and cancels in-flight fetches on redirect.

---
 rtl/inst_fetch_ctrl_if.sv | 23 ++
 rtl/inst_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Instruction SRAM-like bus between the fetch controller (master) and the instruction memory (slave).
// One request at a time: req/addr_ok for the address phase, data_ok/rdata for the response.
interface inst_fetch_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: issues one instruction fetch at a time, cancels in-flight fetches on
// redirect, and hands fetched instructions to decode over a valid/allowin handshake.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                     clk,
    input  logic                     rst,
    inst_fetch_ctrl_if.master        inst_sram,
    input  logic                     br_taken,
    input  logic [31:0]              br_target,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    input  logic                     ds_allowin,
    output logic                     fs_to_ds_valid,
    output logic [31:0]              fs_pc,
    output logic [31:0]              fs_inst
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_r,    state_s;
    logic [31:0] req_addr_r, req_addr_s;
    logic        cancel_r,   cancel_s;
    logic [31:0] pend_pc_r,  pend_pc_s;
    logic        fs_valid_r, fs_valid_s;
    logic [31:0] fs_pc_r,    fs_pc_s;
    logic [31:0] fs_inst_r,  fs_inst_s;
    logic        redir_s;
    logic [31:0] target_s;

    // Redirect request and target; flush outranks a same-cycle branch.
    always_comb begin
        redir_s  = flush | br_taken;
        target_s = flush ? flush_pc : br_target;
    end

    // Next-state and register updates for the fetch sequence.
    always_comb begin
        state_s    = state_r;
        req_addr_s = req_addr_r;
        cancel_s   = cancel_r;
        pend_pc_s  = pend_pc_r;
        fs_valid_s = fs_valid_r;
        fs_pc_s    = fs_pc_r;
        fs_inst_s  = fs_inst_r;

        case (state_r)
            ST_REQ: begin
                // The presented address stays put; a redirect only marks the fetch as stale.
                if (redir_s) begin
                    cancel_s  = 1'b1;
                    pend_pc_s = target_s;
                end else begin
                    cancel_s  = cancel_r;
                    pend_pc_s = pend_pc_r;
                end
                if (inst_sram.addr_ok) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (inst_sram.data_ok) begin
                    if (cancel_r | redir_s) begin
                        req_addr_s = redir_s ? target_s : pend_pc_r;
                        cancel_s   = 1'b0;
                        state_s    = ST_REQ;
                    end else begin
                        fs_inst_s  = inst_sram.rdata;
                        fs_pc_s    = req_addr_r;
                        fs_valid_s = 1'b1;
                        req_addr_s = req_addr_r + 32'd4;
                        state_s    = ST_HOLD;
                    end
                end else if (redir_s) begin
                    cancel_s  = 1'b1;
                    pend_pc_s = target_s;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redir_s) begin
                    fs_valid_s = 1'b0;
                    req_addr_s = target_s;
                    state_s    = ST_REQ;
                end else if (ds_allowin) begin
                    fs_valid_s = 1'b0;
                    state_s    = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s    = ST_REQ;
                req_addr_s = RESET_PC;
                cancel_s   = 1'b0;
                fs_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_REQ;
            req_addr_r <= RESET_PC;
            cancel_r   <= 1'b0;
            pend_pc_r  <= 32'h0000_0000;
            fs_valid_r <= 1'b0;
            fs_pc_r    <= 32'h0000_0000;
            fs_inst_r  <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            req_addr_r <= req_addr_s;
            cancel_r   <= cancel_s;
            pend_pc_r  <= pend_pc_s;
            fs_valid_r <= fs_valid_s;
            fs_pc_r    <= fs_pc_s;
            fs_inst_r  <= fs_inst_s;
        end
    end

    assign inst_sram.req   = (state_r == ST_REQ) & ~rst;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = 2'b10;
    assign inst_sram.wstrb = 4'b0000;
    assign inst_sram.addr  = req_addr_r;
    assign inst_sram.wdata = 32'h0000_0000;

    assign fs_to_ds_valid = fs_valid_r;
    assign fs_pc          = fs_pc_r;
    assign fs_inst        = fs_inst_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus randomized slave/redirect
// traffic checked against a transaction-level fetch model; a second instance checks PC wrap.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RST_PC  = 32'h1c000000;
    localparam logic [31:0] WRAP_PC = 32'hfffffffc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        ds_allowin = 1'b0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_inst;

    int total_cnt = 0;
    int bad_cnt   = 0;

    inst_fetch_ctrl_if bus ();
    inst_fetch_ctrl_if wbus ();

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .inst_sram(bus),
        .br_taken(br_taken), .br_target(br_target),
        .flush(flush), .flush_pc(flush_pc),
        .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst)
    );

    // Second instance: always-ready slave, no redirects, used to observe address wrap.
    inst_fetch_ctrl #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst), .inst_sram(wbus),
        .br_taken(1'b0), .br_target(32'h0),
        .flush(1'b0), .flush_pc(32'h0),
        .ds_allowin(1'b1),
        .fs_to_ds_valid(w_valid), .fs_pc(w_pc), .fs_inst(w_inst)
    );

    assign wbus.addr_ok = 1'b1;
    assign wbus.rdata   = 32'h00ab_0000;

    logic [31:0] wq[$];

    // Wrap-instance slave: respond one cycle after each accepted request.
    always @(posedge clk) begin
        wbus.data_ok <= !rst && wbus.req && wbus.addr_ok;
        if (!rst && wbus.req && wbus.addr_ok && wq.size() < 2) wq.push_back(wbus.addr);
    end

    // Transaction-level model of the fetch stream.
    bit          m_fetching = 1'b1;
    bit          m_pending  = 1'b0;
    bit          m_killed   = 1'b0;
    bit          m_valid    = 1'b0;
    logic [31:0] m_next     = RST_PC;
    logic [31:0] m_redir_pc = 32'h0;
    logic [31:0] m_pc       = 32'h0;
    logic [31:0] m_inst     = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic aok, input logic dok, input logic [31:0] rd,
                        input logic br, input logic [31:0] bt, input logic fl,
                        input logic [31:0] fp, input logic alw);
        logic        redir;
        logic [31:0] tgt;
        rst = r; bus.addr_ok = aok; bus.data_ok = dok; bus.rdata = rd;
        br_taken = br; br_target = bt; flush = fl; flush_pc = fp; ds_allowin = alw;
        #1;
        check_val("req", {31'd0, bus.req}, {31'd0, (!r && m_fetching)});
        if (!r) begin
            if (m_fetching) check_val("addr", bus.addr, m_next);
            check_val("valid", {31'd0, fs_to_ds_valid}, {31'd0, m_valid});
            check_val("fs_pc", fs_pc, m_pc);
            check_val("fs_inst", fs_inst, m_inst);
        end
        redir = fl | br;
        tgt   = fl ? fp : bt;
        if (r) begin
            m_fetching = 1'b1; m_pending = 1'b0; m_killed = 1'b0; m_valid = 1'b0;
            m_next = RST_PC; m_pc = 32'h0; m_inst = 32'h0;
        end else if (m_fetching) begin
            if (redir) begin m_killed = 1'b1; m_redir_pc = tgt; end
            if (aok) begin m_fetching = 1'b0; m_pending = 1'b1; end
        end else if (m_pending) begin
            if (redir) begin m_killed = 1'b1; m_redir_pc = tgt; end
            if (dok) begin
                m_pending = 1'b0;
                if (m_killed) begin
                    m_killed = 1'b0; m_next = m_redir_pc; m_fetching = 1'b1;
                end else begin
                    m_valid = 1'b1; m_pc = m_next; m_inst = rd; m_next = m_next + 32'd4;
                end
            end
        end else if (m_valid) begin
            if (redir) begin
                m_valid = 1'b0; m_next = tgt; m_fetching = 1'b1;
            end else if (alw) begin
                m_valid = 1'b0; m_fetching = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        r, aok, dok, br, fl, alw;
        logic [31:0] rd, bt, fp;
        logic [31:0] w0, w1;

        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = 32'h0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        // Basic fetch at RESET_PC, then decode stalls for five cycles.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Delayed addr_ok with a branch during the address phase.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000100, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Branch and flush together while waiting: flush target wins.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000200, 1'b1, 32'h1c008000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        // Redirect coincident with data_ok.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h55555555, 1'b1, 32'h1c000300, 1'b0, 32'h0, 1'b0);
        // Redirect while holding with decode stalled.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000400, 1'b0, 32'h0, 1'b0);
        // Reset while a transaction is outstanding.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            aok = m_fetching && ($urandom_range(0, 2) != 0);
            dok = m_pending && ($urandom_range(0, 2) == 0);
            rd  = $urandom;
            br  = ($urandom_range(0, 9) == 0);
            bt  = $urandom & 32'hfffffffc;
            fl  = ($urandom_range(0, 15) == 0);
            fp  = $urandom & 32'hfffffffc;
            alw = ($urandom_range(0, 3) != 0);
            step(r, aok, dok, rd, br, bt, fl, fp, alw);
        end

        w0 = (wq.size() > 0) ? wq[0] : 32'hdeadbeef;
        w1 = (wq.size() > 1) ? wq[1] : 32'hdeadbeef;
        check_val("wrap_cnt", wq.size(), 32'd2);
        check_val("wrap_first", w0, WRAP_PC);
        check_val("wrap_second", w1, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
